// File: rtl/cache_pkg.sv
// Shared types for the N-way set-associative write-back cache:
// controller states, the 256-bit line type and the byte-merge helper.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, WB, FILL} cache_state_e;

  localparam int LINE_BYTES = 32;

  typedef logic [255:0] line_t;
  typedef logic [LINE_BYTES-1:0] byte_en_t;

  function automatic line_t merge_bytes(line_t old_line, line_t new_line, byte_en_t be);
    line_t res;
    res = old_line;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (be[b]) res[8*b +: 8] = new_line[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/nway_cache_if.sv
// Line-granular request/response bus, used both on the CPU side (cache is slave)
// and on the physical-memory side (cache is master).
interface nway_cache_if;
  import cache_pkg::*;

  logic [31:0] address;
  logic        read;
  logic        write;
  byte_en_t    byte_enable;
  line_t       wdata;
  line_t       rdata;
  logic        resp;

  modport master (output address, read, write, byte_enable, wdata, input rdata, resp);
  modport slave  (input address, read, write, byte_enable, wdata, output rdata, resp);

endinterface

// File: rtl/plru_tree.sv
// Combinational tree pseudo-LRU: next-state bits for an access and the current victim.
// Node n has children 2n+1 (left) and 2n+2 (right); a 0 bit means the victim is on the left.
module plru_tree #(
  parameter int NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-2:0]         plru_in,
  input  logic [$clog2(NUM_WAYS)-1:0] access_way,
  input  logic                        access_en,
  output logic [NUM_WAYS-2:0]         plru_out,
  output logic [$clog2(NUM_WAYS)-1:0] victim_way
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic [WAY_W-1:0] acc_node;
  logic [WAY_W-1:0] vic_node;

  // Node index at level l = (2**l - 1) + the way-number prefix above that level.
  always_comb begin
    plru_out = plru_in;
    acc_node = '0;
    for (int l = 0; l < WAY_W; l++) begin
      acc_node = WAY_W'((2 ** l) - 1) + (access_way >> (WAY_W - l));
      if (access_en) plru_out[acc_node] = ~access_way[WAY_W-1-l];
    end
  end

  always_comb begin
    victim_way = '0;
    vic_node   = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim_way[WAY_W-1-l] = plru_in[vic_node];
      vic_node = WAY_W'((2 ** (l + 1)) - 1) + (victim_way >> (WAY_W - 1 - l));
    end
  end

endmodule

// File: rtl/nway_cache.sv
// Parametrised N-way set-associative write-back cache with tree-PLRU replacement.
// Optional hit/miss counters are built when NWAY_CACHE_PERF_EN is defined.
module nway_cache
  import cache_pkg::*;
#(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int NUM_WAYS = 4
) (
  input  logic          clk,
  input  logic          rst,
  nway_cache_if.slave   cpu,
  nway_cache_if.master  pmem
`ifdef NWAY_CACHE_PERF_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int WAY_W    = $clog2(NUM_WAYS);

  logic [S_TAG-1:0]    tag_arr   [NUM_SETS][NUM_WAYS];
  line_t               data_arr  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_arr [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_arr [NUM_SETS];
  logic [NUM_WAYS-2:0] plru_arr  [NUM_SETS];

  cache_state_e     state_reg;
  logic [WAY_W-1:0] victim_reg;
  logic             pmem_read_reg;
  logic             pmem_write_reg;
  logic             just_filled_reg;
`ifdef NWAY_CACHE_PERF_EN
  logic [31:0]      hit_cnt_reg;
  logic [31:0]      miss_cnt_reg;
`endif

  logic [S_INDEX-1:0]  idx;
  logic [S_TAG-1:0]    req_tag;
  logic                req;
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit;
  logic                idle_hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    plru_victim;
  logic [WAY_W-1:0]    victim_next;
  logic [NUM_WAYS-2:0] plru_next;
  logic                unused_offset;

  assign idx           = cpu.address[S_OFFSET +: S_INDEX];
  assign req_tag       = cpu.address[31 -: S_TAG];
  assign req           = cpu.read | cpu.write;
  assign unused_offset = ^cpu.address[S_OFFSET-1:0];

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_tag_cmp
    assign hit_vec[gi] = valid_arr[idx][gi] && (tag_arr[idx][gi] == req_tag);
  end

  assign hit      = |hit_vec;
  assign idle_hit = (state_reg == IDLE) && req && hit;

  // Descending scans so the lowest-numbered matching / invalid way wins.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w])         hit_way = WAY_W'(w);
      if (!valid_arr[idx][w]) inv_way = WAY_W'(w);
    end
  end

  assign victim_next = (&valid_arr[idx]) ? plru_victim : inv_way;

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .plru_in    (plru_arr[idx]),
    .access_way (hit_way),
    .access_en  (idle_hit),
    .plru_out   (plru_next),
    .victim_way (plru_victim)
  );

  assign cpu.resp          = idle_hit;
  assign cpu.rdata         = data_arr[idx][hit_way];
  assign pmem.read         = pmem_read_reg;
  assign pmem.write        = pmem_write_reg;
  assign pmem.byte_enable  = '1;
  assign pmem.wdata        = data_arr[idx][victim_reg];
  assign pmem.address      = (state_reg == WB) ? {tag_arr[idx][victim_reg], idx, {S_OFFSET{1'b0}}}
                                               : {req_tag, idx, {S_OFFSET{1'b0}}};
`ifdef NWAY_CACHE_PERF_EN
  assign hit_count  = hit_cnt_reg;
  assign miss_count = miss_cnt_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      victim_reg      <= '0;
      pmem_read_reg   <= 1'b0;
      pmem_write_reg  <= 1'b0;
      just_filled_reg <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
`ifdef NWAY_CACHE_PERF_EN
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
`endif
    end else begin
      just_filled_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (req && hit) begin
            plru_arr[idx] <= plru_next;
            if (cpu.write) begin
              data_arr[idx][hit_way]  <= merge_bytes(data_arr[idx][hit_way], cpu.wdata, cpu.byte_enable);
              dirty_arr[idx][hit_way] <= 1'b1;
            end
`ifdef NWAY_CACHE_PERF_EN
            // The hit that completes a miss is not a hit in its own right.
            if (!just_filled_reg && hit_cnt_reg != 32'hFFFF_FFFF) hit_cnt_reg <= hit_cnt_reg + 32'd1;
`endif
          end else if (req) begin
            victim_reg <= victim_next;
            if (valid_arr[idx][victim_next] && dirty_arr[idx][victim_next]) begin
              state_reg      <= WB;
              pmem_write_reg <= 1'b1;
            end else begin
              state_reg     <= FILL;
              pmem_read_reg <= 1'b1;
            end
`ifdef NWAY_CACHE_PERF_EN
            if (miss_cnt_reg != 32'hFFFF_FFFF) miss_cnt_reg <= miss_cnt_reg + 32'd1;
`endif
          end
        end
        WB: begin
          if (pmem.resp) begin
            state_reg      <= FILL;
            pmem_write_reg <= 1'b0;
            pmem_read_reg  <= 1'b1;
          end
        end
        FILL: begin
          if (pmem.resp) begin
            data_arr[idx][victim_reg]  <= pmem.rdata;
            tag_arr[idx][victim_reg]   <= req_tag;
            valid_arr[idx][victim_reg] <= 1'b1;
            dirty_arr[idx][victim_reg] <= 1'b0;
            state_reg                  <= IDLE;
            pmem_read_reg              <= 1'b0;
            just_filled_reg            <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nway_cache.sv
// Self-checking bench for nway_cache: directed scenarios plus random traffic against
// a behavioural set/way model with its own backing memory. Honours NWAY_CACHE_PERF_EN.
module tb_nway_cache;
  import cache_pkg::*;

  localparam int PERIOD = 10;
  localparam int SETS = 8, WAYS = 4, LV = 2;

  logic clk = 1'b0;
  logic rst;
  always #(PERIOD/2) clk = ~clk;

  nway_cache_if cpu ();
  nway_cache_if pmem ();
`ifdef NWAY_CACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  nway_cache dut (
    .clk  (clk),
    .rst  (rst),
    .cpu  (cpu.slave),
    .pmem (pmem.master)
`ifdef NWAY_CACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  typedef struct {logic [31:0] addr; line_t data;} wb_t;
  line_t phys_mem [int unsigned];
  line_t model_mem [int unsigned];
  wb_t   wb_q [$];
  int    fills = 0;
  time   last_resp_time = 0;
  bit    hold_resp = 1'b0;

  // Behavioural cache state: plain arrays, PLRU kept as a heap of node bits.
  logic [23:0] m_tag   [SETS][WAYS];
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  line_t       m_data  [SETS][WAYS];
  bit          m_plru  [SETS][WAYS-1];

  // Results of the last transaction.
  bit    obs_hit, exp_hit, exp_wb, tmo;
  line_t obs_rd, exp_rd;
  int    obs_wb_n, obs_fills;
  wb_t   obs_wb, exp_wbv;
  time   resp_seen;

  function automatic line_t init_line(logic [31:0] a);
    line_t l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = 32'(a * (w + 3)) ^ 32'hC3C3_0000;
    return l;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
      for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 1'b0;
    end
  endfunction

  function automatic void plru_touch(int s, int way);
    int node = 0;
    for (int l = 0; l < LV; l++) begin
      int d = (way >> (LV - 1 - l)) & 1;
      m_plru[s][node] = (d == 0);
      node = 2 * node + 1 + d;
    end
  endfunction

  function automatic int plru_pick(int s);
    int node = 0, v = 0;
    for (int l = 0; l < LV; l++) begin
      int d = int'(m_plru[s][node]);
      v = 2 * v + d;
      node = 2 * node + 1 + d;
    end
    return v;
  endfunction

  task automatic model_access(input logic [31:0] addr, input bit wr, input byte_en_t be, input line_t wd);
    int s = int'(addr[7:5]);
    logic [23:0] t = addr[31:8];
    logic [31:0] la = {addr[31:5], 5'b0};
    int way = -1;
    for (int w = 0; w < WAYS; w++) if (way < 0 && m_valid[s][w] && m_tag[s][w] == t) way = w;
    exp_hit = (way >= 0);
    exp_wb  = 1'b0;
    if (way < 0) begin
      for (int w = 0; w < WAYS; w++) if (way < 0 && !m_valid[s][w]) way = w;
      if (way < 0) way = plru_pick(s);
      if (m_valid[s][way] && m_dirty[s][way]) begin
        exp_wb = 1'b1;
        exp_wbv.addr = {m_tag[s][way], addr[7:5], 5'b0};
        exp_wbv.data = m_data[s][way];
        model_mem[exp_wbv.addr] = m_data[s][way];
      end
      m_data[s][way]  = model_mem.exists(la) ? model_mem[la] : init_line(la);
      m_tag[s][way]   = t;
      m_valid[s][way] = 1'b1;
      m_dirty[s][way] = 1'b0;
    end
    plru_touch(s, way);
    if (wr) begin
      for (int b = 0; b < 32; b++) if (be[b]) m_data[s][way][8*b +: 8] = wd[8*b +: 8];
      m_dirty[s][way] = 1'b1;
    end
    exp_rd = m_data[s][way];
  endtask

  // Physical memory: random 0-3 cycle latency, one-cycle resp pulse.
  initial begin
    int cnt = -1;
    forever begin
      @(negedge clk);
      if (pmem.resp) begin
        pmem.resp = 1'b0;
        cnt = -1;
      end else if (rst || hold_resp || !(pmem.read || pmem.write)) begin
        cnt = -1;
      end else begin
        if (cnt < 0) cnt = int'($urandom_range(0, 3));
        if (cnt == 0) begin
          if (pmem.write) begin
            wb_q.push_back('{pmem.address, pmem.wdata});
            phys_mem[pmem.address] = pmem.wdata;
          end else begin
            pmem.rdata = phys_mem.exists(pmem.address) ? phys_mem[pmem.address] : init_line(pmem.address);
            fills++;
          end
          pmem.resp = 1'b1;
          last_resp_time = $time;
          cnt = -1;
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic dut_access(input logic [31:0] addr, input bit rd, input bit wr,
                            input byte_en_t be, input line_t wd, output int cycles);
    bit done = 1'b0;
    @(negedge clk);
    cpu.address = addr; cpu.read = rd; cpu.write = wr; cpu.byte_enable = be; cpu.wdata = wd;
    cycles = 0; tmo = 1'b0; resp_seen = 0;
    while (!done) begin
      #1;
      if (cpu.resp === 1'b1) begin
        obs_rd = cpu.rdata;
        resp_seen = $time;
        done = 1'b1;
        @(posedge clk);
      end else if (cycles >= 200) begin
        tmo = 1'b1;
        done = 1'b1;
      end else begin
        @(posedge clk);
        cycles++;
        @(negedge clk);
      end
    end
    #1;
    cpu.read = 1'b0; cpu.write = 1'b0;
  endtask

  task automatic xact(input logic [31:0] addr, input bit rd, input bit wr, input byte_en_t be, input line_t wd);
    int cycles;
    int f0 = fills;
    wb_q.delete();
    model_access(addr, wr, be, wd);
    dut_access(addr, rd, wr, be, wd, cycles);
    obs_hit   = (cycles == 0) && !tmo;
    obs_wb_n  = wb_q.size();
    obs_fills = fills - f0;
    if (obs_wb_n > 0) obs_wb = wb_q[0];
    $display("xact addr=%h rd=%0b wr=%0b cycles=%0d hit=%0b wb=%0d exp_hit=%0b exp_wb=%0b",
             addr, rd, wr, cycles, obs_hit, obs_wb_n, exp_hit, exp_wb);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; hold_resp = 1'b0;
    cpu.read = 1'b0; cpu.write = 1'b0; cpu.address = '0; cpu.byte_enable = '0; cpu.wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    phys_mem.delete();
    model_mem.delete();
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    vectors++; if (cpu.resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", cpu.resp); end
    vectors++; if (pmem.read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read: got %b want 0", pmem.read); end
    vectors++; if (pmem.write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write: got %b want 0", pmem.write); end
    cpu.address = 32'h100; cpu.read = 1'b1;
    #1;
    vectors++; if (cpu.resp !== 1'b0) begin errors++; $display("FAIL reset_no_hit: got %b want 0", cpu.resp); end
    cpu.read = 1'b0;
  endtask

  task automatic test_cold_read();
    reset_dut();
    xact(32'h100, 1'b1, 1'b0, '0, '0);
    vectors++; if (tmo !== 1'b0) begin errors++; $display("FAIL cold_timeout: got %b want 0", tmo); end
    vectors++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL cold_hit: got %b want 0", obs_hit); end
    vectors++; if (obs_rd !== init_line(32'h100)) begin errors++; $display("FAIL cold_data: got %h want %h", obs_rd, init_line(32'h100)); end
    vectors++; if (obs_wb_n !== 0) begin errors++; $display("FAIL cold_wb: got %0d want 0", obs_wb_n); end
    vectors++; if (obs_fills !== 1) begin errors++; $display("FAIL cold_fills: got %0d want 1", obs_fills); end
    vectors++; if (resp_seen - last_resp_time !== PERIOD + 1) begin
      errors++; $display("FAIL cold_latency: got %0t want %0d", resp_seen - last_resp_time, PERIOD + 1);
    end
  endtask

  task automatic test_hit_read();
    xact(32'h100, 1'b1, 1'b0, '0, '0);
    vectors++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL hit_same_cycle: got %b want 1", obs_hit); end
    vectors++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL hit_data: got %h want %h", obs_rd, exp_rd); end
    vectors++; if (obs_fills !== 0) begin errors++; $display("FAIL hit_no_fill: got %0d want 0", obs_fills); end
  endtask

  task automatic test_writeback();
    line_t wd = {8{$urandom}};
    line_t want;
    logic [31:0] addrs [4] = '{32'h200, 32'h300, 32'h400, 32'h500};
    want = init_line(32'h100);
    want[31:0] = 32'hAAAA_AAAA;
    wd[31:0] = 32'hAAAA_AAAA;
    reset_dut();
    xact(32'h100, 1'b1, 1'b0, '0, '0);
    xact(32'h100, 1'b0, 1'b1, 32'h0000_000F, wd);
    vectors++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL wb_write_hit: got %b want 1", obs_hit); end
    foreach (addrs[i]) begin
      xact(addrs[i], 1'b1, 1'b0, '0, '0);
      vectors++; if (obs_wb_n !== (i == 3 ? 1 : 0)) begin errors++; $display("FAIL wb_count_%0d: got %0d want %0d", i, obs_wb_n, (i == 3 ? 1 : 0)); end
    end
    vectors++; if (obs_wb.addr !== 32'h100) begin errors++; $display("FAIL wb_addr: got %h want 00000100", obs_wb.addr); end
    vectors++; if (obs_wb.data !== want) begin errors++; $display("FAIL wb_data: got %h want %h", obs_wb.data, want); end
  endtask

  task automatic test_plru();
    logic [31:0] seq [6] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h100, 32'h300};
    logic [31:0] keep [4] = '{32'h100, 32'h300, 32'h400, 32'h500};
    reset_dut();
    foreach (seq[i]) xact(seq[i], 1'b1, 1'b0, '0, '0);
    xact(32'h500, 1'b1, 1'b0, '0, '0);
    vectors++; if (obs_wb_n !== 0) begin errors++; $display("FAIL plru_no_wb: got %0d want 0", obs_wb_n); end
    foreach (keep[i]) begin
      xact(keep[i], 1'b1, 1'b0, '0, '0);
      vectors++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL plru_kept_%h: got %b want 1", keep[i], obs_hit); end
    end
    xact(32'h200, 1'b1, 1'b0, '0, '0);
    vectors++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL plru_evicted_200: got %b want 0", obs_hit); end
  endtask

  task automatic test_rw_both();
    line_t wd = {8{$urandom}};
    byte_en_t be = $urandom;
    logic [31:0] evict [4] = '{32'h700, 32'h800, 32'h900, 32'hA00};
    reset_dut();
    xact(32'h600, 1'b1, 1'b0, '0, '0);
    xact(32'h600, 1'b1, 1'b1, be, wd);
    vectors++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL rw_resp: got %b want 1", obs_hit); end
    xact(32'h600, 1'b1, 1'b0, '0, '0);
    vectors++; if (obs_rd !== merge_bytes(init_line(32'h600), wd, be)) begin
      errors++; $display("FAIL rw_merged: got %h want %h", obs_rd, merge_bytes(init_line(32'h600), wd, be));
    end
    foreach (evict[i]) xact(evict[i], 1'b1, 1'b0, '0, '0);
    vectors++; if (obs_wb_n !== 1 || obs_wb.addr !== 32'h600) begin
      errors++; $display("FAIL rw_dirty_wb: got n=%0d addr=%h want n=1 addr=00000600", obs_wb_n, obs_wb.addr);
    end
  endtask

  task automatic test_reset_mid_fill();
    int waited = 0;
    reset_dut();
    xact(32'h120, 1'b1, 1'b0, '0, '0);
    hold_resp = 1'b1;
    @(negedge clk);
    cpu.address = 32'h700; cpu.read = 1'b1;
    while (pmem.read !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    vectors++; if (pmem.read !== 1'b1) begin errors++; $display("FAIL midfill_start: got %b want 1", pmem.read); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (pmem.read !== 1'b0) begin errors++; $display("FAIL midfill_abort: got %b want 0", pmem.read); end
    @(negedge clk);
    rst = 1'b0; cpu.read = 1'b0; hold_resp = 1'b0;
    model_reset();
    xact(32'h700, 1'b1, 1'b0, '0, '0);
    vectors++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL midfill_reread_miss: got %b want 0", obs_hit); end
    xact(32'h120, 1'b1, 1'b0, '0, '0);
    vectors++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL midfill_old_line_miss: got %b want 0", obs_hit); end
  endtask

  task automatic test_random();
    reset_dut();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] addr = {16'h0, 5'($urandom_range(0, 5)), 3'b0, 3'($urandom_range(0, 1)), 5'($urandom)};
      int op = int'($urandom_range(0, 3));
      bit rd = (op != 2);
      bit wr = (op >= 2);
      xact(addr, rd, wr, $urandom, {8{$urandom}});
      vectors++; if (obs_hit !== exp_hit || tmo) begin errors++; $display("FAIL rnd_hit[%0d]: got %b want %b", n, obs_hit, exp_hit); end
      if (!wr) begin
        vectors++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", n, obs_rd, exp_rd); end
      end
      vectors++; if (obs_wb_n !== int'(exp_wb)) begin errors++; $display("FAIL rnd_wb_n[%0d]: got %0d want %0d", n, obs_wb_n, exp_wb); end
      if (exp_wb && obs_wb_n == 1) begin
        vectors++; if (obs_wb !== exp_wbv) begin
          errors++; $display("FAIL rnd_wb[%0d]: got %h/%h want %h/%h", n, obs_wb.addr, obs_wb.data, exp_wbv.addr, exp_wbv.data);
        end
      end
    end
  endtask

`ifdef NWAY_CACHE_PERF_EN
  task automatic test_perf();
    reset_dut();
    xact(32'h100, 1'b1, 1'b0, '0, '0);
    xact(32'h100, 1'b1, 1'b0, '0, '0);
    #1;
    vectors++; if (hit_count !== 32'd1) begin errors++; $display("FAIL perf_hits: got %0d want 1", hit_count); end
    vectors++; if (miss_count !== 32'd1) begin errors++; $display("FAIL perf_misses: got %0d want 1", miss_count); end
  endtask
`endif

  initial begin
    #(500_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pmem.resp = 1'b0; pmem.rdata = '0;
    cpu.read = 1'b0; cpu.write = 1'b0; cpu.address = '0; cpu.byte_enable = '0; cpu.wdata = '0;
    test_reset();
    test_cold_read();
    test_hit_read();
    test_writeback();
    test_plru();
    test_rw_both();
    test_reset_mid_fill();
    test_random();
`ifdef NWAY_CACHE_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
